sine_wave_analyzer: RTL and testbench
=====================================

// Module: sine_wave_analyzer
// PURPOSE
//  Receive end of the sine sample stream. Consumes the 8-bit unsigned samples from the waveform generator.
//  Tracks direction with hysteresis and measures period (samples between troughs), peak and trough per cycle.
//  Flags an idle (flat) stream. Sits downstream of the generator or ADC path, feeding status/display logic.
// PARAMETERS
//  DATA_W      8    sample width, unsigned
//  CNT_W       16   period counter width, saturating
//  HYST        2    minimum change from running extremum that counts as a direction reversal
//  IDLE_LIMIT  64   consecutive equal valid samples that declare the stream idle
// PORTS
//  Clk         in   1        clock, rising edge
//  rst         in   1        reset, synchronous, active-high
//  sample_in   in   DATA_W   input sample
//  sample_vld  in   1        sample_in valid this cycle; low = stall, no state change
//  period_out  out  CNT_W    valid samples from previous trough event to current one
//  peak_out    out  DATA_W   maximum of last completed cycle
//  trough_out  out  DATA_W   minimum of last completed cycle
//  period_ovf  out  1        period counter saturated during the measured cycle
//  meas_vld    out  1        1-cycle pulse: period/peak/trough/ovf updated
//  rev_evt     out  1        1-cycle pulse on any direction reversal
//  dir_out     out  1        1 = rising, 0 = falling (meaningful only when idle_out=0)
//  idle_out    out  1        stream flat, no measurement in progress
// BEHAVIOUR
//  Reset: state S_IDLE, all outputs 0, have_ref=0, counters 0. Applies at any time and aborts a cycle in progress.
//  FSM (advances only on sample_vld=1); states S_IDLE, S_RISE, S_FALL:
//   S_IDLE: latch last sample. First sample != last: go S_RISE if greater, else S_FALL. max=min=sample.
//   S_RISE: max=max(max,s). If s+HYST <= max: go S_FALL, peak_r=max, min=s, rev_evt.
//   S_FALL: min=min(min,s). If s >= min+HYST: go S_RISE, trough_r=min, max=s, rev_evt. This is a TROUGH EVENT.
//  Trough event:
//   - If have_ref=1: period_out=cnt, peak_out=peak_r, trough_out=trough_r, period_ovf=sat, meas_vld=1.
//   - Then have_ref=1, cnt=1, sat=0.
//  cnt increments on every valid sample outside S_IDLE. It saturates at 2^CNT_W-1 and sets sat.
//  Compare arithmetic uses DATA_W+1 bits. No wrap on s+HYST or min+HYST.
//  Idle detect: run counter of consecutive valid samples equal to previous valid sample. Reset on difference.
//   Reaching IDLE_LIMIT forces S_IDLE, idle_out=1, have_ref=0, cnt=0.
//   Idle has priority over a reversal/trough event on the same sample; no meas_vld then.
//  Latency: all outputs registered. meas_vld and rev_evt are high the cycle after the triggering sample is accepted.
//  Measurement outputs hold until next meas_vld or reset.
//  sample_vld=0: nothing changes. Pulses still drop after one cycle.
//  Plateaus (e.g. 127,127,127) shorter than IDLE_LIMIT do not reverse direction.
// STRUCTURE
//  Shared include waveform_defs.vh holds:
//   - state encodings S_IDLE=2'd0, S_RISE=2'd1, S_FALL=2'd2
//   - generator table length 35 and sample width 8, also used by the generator
//  One sub-module: wave_idle_detect (run-length counter with equality compare, outputs idle_hit).
//  The FSM, extremum tracking and period counter stay in the top module.
// TESTING
//  1 Feed generator 35-entry table (0,4,...,127,...,1,0), wrapping every 35 samples, vld=1.
//    -> first meas_vld at 2nd trough event; period_out=35, peak_out=127, trough_out=0, period_ovf=0, every 35 samples.
//  2 Same table, step 2 (18 samples/cycle) -> period_out=18, peak_out=127, trough_out=0.
//  3 Case 1 with vld low every other cycle -> identical outputs; meas_vld spacing 70 cycles.
//  4 Hold sample_in=0 for 64 valid samples mid-cycle -> idle_out=1 the cycle after the 64th sample.
//    Resume table -> no meas_vld until two trough events seen.
//  5 CNT_W=8, triangle 0->150->0 in unit steps (300 samples/cycle) -> period_out=255, period_ovf=1.
//  6 Assert rst for 1 cycle mid-rise -> all outputs 0, idle_out=0, state S_IDLE. Next measurement needs two troughs.

Source files
------------

// File: rtl/sine_wave_analyzer_pkg.sv
// Shared definitions for the sine sample stream analyzer and its waveform source.
package sine_wave_analyzer_pkg;

   // Sample width produced by the waveform generator
   localparam int unsigned GEN_SAMPLE_W = 8;

   // Direction-tracking states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RISE = 2'd1,
      S_FALL = 2'd2
   } wave_state_t;

endpackage

// File: rtl/sine_wave_analyzer_idle_detect.sv
// Run-length detector: flags when IDLE_LIMIT consecutive valid samples are identical.
module wave_idle_detect
   import sine_wave_analyzer_pkg::*;
#(
   parameter int unsigned DATA_W     = GEN_SAMPLE_W,
   parameter int unsigned IDLE_LIMIT = 64
) (
   input  logic              Clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_sample,
   input  logic              i_vld,
   output logic              o_idle_hit
);

   localparam int unsigned RUN_W = $clog2(IDLE_LIMIT + 1);

   logic [DATA_W-1:0] r_prev;
   logic              r_have_prev;
   logic [RUN_W-1:0]  r_run;

   logic              w_same;
   logic [RUN_W-1:0]  w_run_next;

   // Run length including the current sample; saturates at the limit so a
   // stream that stays flat keeps reporting the hit.
   always_comb begin
      w_same     = r_have_prev && (i_sample == r_prev);
      w_run_next = RUN_W'(1);
      if (w_same) begin
         if (r_run == RUN_W'(IDLE_LIMIT)) begin
            w_run_next = r_run;
         end else begin
            w_run_next = r_run + RUN_W'(1);
         end
      end
      o_idle_hit = i_vld && (w_run_next == RUN_W'(IDLE_LIMIT));
   end

   // Track the previous valid sample and the current run length
   always_ff @(posedge Clk) begin
      if (rst) begin
         r_prev      <= '0;
         r_have_prev <= 1'b0;
         r_run       <= '0;
      end else if (i_vld) begin
         r_prev      <= i_sample;
         r_have_prev <= 1'b1;
         r_run       <= w_run_next;
      end
   end

endmodule

// File: rtl/sine_wave_analyzer.sv
// Receive side of the sine sample stream: direction tracking with hysteresis,
// per-cycle period/peak/trough measurement and flat-stream detection.
module sine_wave_analyzer
   import sine_wave_analyzer_pkg::*;
#(
   parameter int unsigned DATA_W     = GEN_SAMPLE_W,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned HYST       = 2,
   parameter int unsigned IDLE_LIMIT = 64
) (
   input  logic              Clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_vld,
   output logic [CNT_W-1:0]  period_out,
   output logic [DATA_W-1:0] peak_out,
   output logic [DATA_W-1:0] trough_out,
   output logic              period_ovf,
   output logic              meas_vld,
   output logic              rev_evt,
   output logic              dir_out,
   output logic              idle_out
);

   localparam int unsigned EXT_W = DATA_W + 1;

   // Architectural state
   wave_state_t       r_state;
   logic [DATA_W-1:0] r_last;
   logic              r_have_last;
   logic [DATA_W-1:0] r_max;
   logic [DATA_W-1:0] r_min;
   logic [DATA_W-1:0] r_peak_r;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sat;
   logic              r_have_ref;
   logic [CNT_W-1:0]  r_period;
   logic [DATA_W-1:0] r_peak;
   logic [DATA_W-1:0] r_trough;
   logic              r_ovf;
   logic              r_meas;
   logic              r_rev;
   logic              r_dir;
   logic              r_idle;

   // Next-state values
   wave_state_t       w_state_nxt;
   logic [DATA_W-1:0] w_last_nxt;
   logic              w_have_last_nxt;
   logic [DATA_W-1:0] w_max_nxt;
   logic [DATA_W-1:0] w_min_nxt;
   logic [DATA_W-1:0] w_peak_r_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_sat_nxt;
   logic              w_have_ref_nxt;
   logic [CNT_W-1:0]  w_period_nxt;
   logic [DATA_W-1:0] w_peak_nxt;
   logic [DATA_W-1:0] w_trough_nxt;
   logic              w_ovf_nxt;
   logic              w_meas_nxt;
   logic              w_rev_nxt;
   logic              w_dir_nxt;
   logic              w_idle_nxt;

   // Helpers
   logic              w_idle_hit;
   logic [DATA_W-1:0] w_max_upd;
   logic [DATA_W-1:0] w_min_upd;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_sat_inc;
   logic [EXT_W-1:0]  w_s_ext;
   logic [EXT_W-1:0]  w_hyst;

   wave_idle_detect #(
      .DATA_W     (DATA_W),
      .IDLE_LIMIT (IDLE_LIMIT)
   ) u_idle_detect (
      .Clk        (Clk),
      .rst        (rst),
      .i_sample   (sample_in),
      .i_vld      (sample_vld),
      .o_idle_hit (w_idle_hit)
   );

   assign w_s_ext   = {1'b0, sample_in};
   assign w_hyst    = EXT_W'(HYST);
   assign w_max_upd = (sample_in > r_max) ? sample_in : r_max;
   assign w_min_upd = (sample_in < r_min) ? sample_in : r_min;
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_sat_inc = (r_cnt == '1) ? 1'b1 : r_sat;

   // Next-state and output decode; nothing moves on a stalled cycle except
   // the single-cycle pulses, which always fall back to zero.
   always_comb begin
      w_state_nxt     = r_state;
      w_last_nxt      = r_last;
      w_have_last_nxt = r_have_last;
      w_max_nxt       = r_max;
      w_min_nxt       = r_min;
      w_peak_r_nxt    = r_peak_r;
      w_cnt_nxt       = r_cnt;
      w_sat_nxt       = r_sat;
      w_have_ref_nxt  = r_have_ref;
      w_period_nxt    = r_period;
      w_peak_nxt      = r_peak;
      w_trough_nxt    = r_trough;
      w_ovf_nxt       = r_ovf;
      w_meas_nxt      = 1'b0;
      w_rev_nxt       = 1'b0;
      w_dir_nxt       = r_dir;
      w_idle_nxt      = r_idle;

      if (sample_vld) begin
         if (w_idle_hit) begin
            // Flat stream wins over any reversal on this same sample
            w_state_nxt     = S_IDLE;
            w_idle_nxt      = 1'b1;
            w_have_ref_nxt  = 1'b0;
            w_cnt_nxt       = '0;
            w_sat_nxt       = 1'b0;
            w_last_nxt      = sample_in;
            w_have_last_nxt = 1'b1;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  w_last_nxt      = sample_in;
                  w_have_last_nxt = 1'b1;
                  if (r_have_last && (sample_in != r_last)) begin
                     w_state_nxt = (sample_in > r_last) ? S_RISE : S_FALL;
                     w_dir_nxt   = (sample_in > r_last);
                     w_max_nxt   = sample_in;
                     w_min_nxt   = sample_in;
                     w_idle_nxt  = 1'b0;
                  end
               end
               S_RISE: begin
                  w_cnt_nxt = w_cnt_inc;
                  w_sat_nxt = w_sat_inc;
                  w_max_nxt = w_max_upd;
                  if ((w_s_ext + w_hyst) <= {1'b0, w_max_upd}) begin
                     w_state_nxt  = S_FALL;
                     w_dir_nxt    = 1'b0;
                     w_peak_r_nxt = w_max_upd;
                     w_min_nxt    = sample_in;
                     w_rev_nxt    = 1'b1;
                  end
               end
               S_FALL: begin
                  w_min_nxt = w_min_upd;
                  if (w_s_ext >= ({1'b0, w_min_upd} + w_hyst)) begin
                     // Trough event: the count excludes this sample, which
                     // becomes the first sample of the next period.
                     w_state_nxt = S_RISE;
                     w_dir_nxt   = 1'b1;
                     w_max_nxt   = sample_in;
                     w_rev_nxt   = 1'b1;
                     if (r_have_ref) begin
                        w_period_nxt = r_cnt;
                        w_peak_nxt   = r_peak_r;
                        w_trough_nxt = w_min_upd;
                        w_ovf_nxt    = r_sat;
                        w_meas_nxt   = 1'b1;
                     end
                     w_have_ref_nxt = 1'b1;
                     w_cnt_nxt      = CNT_W'(1);
                     w_sat_nxt      = 1'b0;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                     w_sat_nxt = w_sat_inc;
                  end
               end
               default: begin
                  w_state_nxt = S_IDLE;
               end
            endcase
         end
      end
   end

   // State and registered-output update with synchronous reset
   always_ff @(posedge Clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last      <= '0;
         r_have_last <= 1'b0;
         r_max       <= '0;
         r_min       <= '0;
         r_peak_r    <= '0;
         r_cnt       <= '0;
         r_sat       <= 1'b0;
         r_have_ref  <= 1'b0;
         r_period    <= '0;
         r_peak      <= '0;
         r_trough    <= '0;
         r_ovf       <= 1'b0;
         r_meas      <= 1'b0;
         r_rev       <= 1'b0;
         r_dir       <= 1'b0;
         r_idle      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_last      <= w_last_nxt;
         r_have_last <= w_have_last_nxt;
         r_max       <= w_max_nxt;
         r_min       <= w_min_nxt;
         r_peak_r    <= w_peak_r_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sat       <= w_sat_nxt;
         r_have_ref  <= w_have_ref_nxt;
         r_period    <= w_period_nxt;
         r_peak      <= w_peak_nxt;
         r_trough    <= w_trough_nxt;
         r_ovf       <= w_ovf_nxt;
         r_meas      <= w_meas_nxt;
         r_rev       <= w_rev_nxt;
         r_dir       <= w_dir_nxt;
         r_idle      <= w_idle_nxt;
      end
   end

   assign period_out = r_period;
   assign peak_out   = r_peak;
   assign trough_out = r_trough;
   assign period_ovf = r_ovf;
   assign meas_vld   = r_meas;
   assign rev_evt    = r_rev;
   assign dir_out    = r_dir;
   assign idle_out   = r_idle;

endmodule

// File: tb/tb_sine_wave_analyzer.sv
// Self-checking bench: two analyzers (16-bit and 8-bit period counters) share
// one stimulus stream and are compared every cycle against a sample-level model.
module tb_sine_wave_analyzer;

   localparam int HYST  = 2;
   localparam int LIMIT = 64;

   logic        Clk = 1'b0;
   logic        rst;
   logic        sample_vld;
   logic [7:0]  sample_in;

   logic [15:0] a_period;
   logic [7:0]  a_peak, a_trough;
   logic        a_ovf, a_meas, a_rev, a_dir, a_idle;
   logic [7:0]  b_period;
   logic [7:0]  b_peak, b_trough;
   logic        b_ovf, b_meas, b_rev, b_dir, b_idle;

   sine_wave_analyzer #(.DATA_W(8), .CNT_W(16), .HYST(HYST), .IDLE_LIMIT(LIMIT)) dut_a (
      .Clk(Clk), .rst(rst), .sample_in(sample_in), .sample_vld(sample_vld),
      .period_out(a_period), .peak_out(a_peak), .trough_out(a_trough),
      .period_ovf(a_ovf), .meas_vld(a_meas), .rev_evt(a_rev),
      .dir_out(a_dir), .idle_out(a_idle)
   );

   sine_wave_analyzer #(.DATA_W(8), .CNT_W(8), .HYST(HYST), .IDLE_LIMIT(LIMIT)) dut_b (
      .Clk(Clk), .rst(rst), .sample_in(sample_in), .sample_vld(sample_vld),
      .period_out(b_period), .peak_out(b_peak), .trough_out(b_trough),
      .period_ovf(b_ovf), .meas_vld(b_meas), .rev_evt(b_rev),
      .dir_out(b_dir), .idle_out(b_idle)
   );

   always #5 Clk = ~Clk;

   // Model of the analyzer at the level of accepted samples
   typedef struct {
      int trend;       // +1 rising, -1 falling, 0 no trend yet / flat
      bit have_last;
      int last;
      bit have_prev;
      int prev;
      int run;
      int hi;
      int lo;
      int pk;
      int cnt;
      bit sat;
      bit have_ref;
      int period;
      int peak;
      int trough;
      bit ovf;
      bit meas;
      bit rev;
      bit dir_o;
      bit idle;
   } mdl_t;

   mdl_t ma, mb;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   int unsigned cyc_no = 0;
   int unsigned n_meas_a, n_meas_b, last_meas_a, gap_a;
   int tbl[35];

   function automatic mdl_t m_clear();
      mdl_t m;
      m = '{default: 0};
      return m;
   endfunction

   function automatic mdl_t m_step(input mdl_t m_in, input bit v, input int s, input int cmax);
      mdl_t m;
      m = m_in;
      m.meas = 0;
      m.rev  = 0;
      if (!v) return m;
      if (m.have_prev && s == m.prev) m.run = (m.run < LIMIT) ? m.run + 1 : LIMIT;
      else m.run = 1;
      m.prev = s;
      m.have_prev = 1;
      if (m.run >= LIMIT) begin
         m.trend = 0; m.idle = 1; m.have_ref = 0; m.cnt = 0; m.sat = 0;
         m.last = s; m.have_last = 1;
         return m;
      end
      if (m.trend == 0) begin
         if (m.have_last && s != m.last) begin
            m.trend = (s > m.last) ? 1 : -1;
            m.dir_o = (s > m.last);
            m.hi = s; m.lo = s; m.idle = 0;
         end
         m.last = s; m.have_last = 1;
         return m;
      end
      if (m.trend == 1) begin
         if (m.cnt == cmax) m.sat = 1; else m.cnt++;
         if (s > m.hi) m.hi = s;
         if (s + HYST <= m.hi) begin
            m.trend = -1; m.dir_o = 0; m.pk = m.hi; m.lo = s; m.rev = 1;
         end
         return m;
      end
      if (s < m.lo) m.lo = s;
      if (s >= m.lo + HYST) begin
         m.trend = 1; m.dir_o = 1; m.hi = s; m.rev = 1;
         if (m.have_ref) begin
            m.period = m.cnt; m.peak = m.pk; m.trough = m.lo; m.ovf = m.sat; m.meas = 1;
         end
         m.have_ref = 1; m.cnt = 1; m.sat = 0;
      end else begin
         if (m.cnt == cmax) m.sat = 1; else m.cnt++;
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_no);
      end
   endtask

   task automatic check_all();
      chk("a.period", 32'(a_period), ma.period);
      chk("a.peak",   32'(a_peak),   ma.peak);
      chk("a.trough", 32'(a_trough), ma.trough);
      chk("a.ovf",    32'(a_ovf),    32'(ma.ovf));
      chk("a.meas",   32'(a_meas),   32'(ma.meas));
      chk("a.rev",    32'(a_rev),    32'(ma.rev));
      chk("a.dir",    32'(a_dir),    32'(ma.dir_o));
      chk("a.idle",   32'(a_idle),   32'(ma.idle));
      chk("b.period", 32'(b_period), mb.period);
      chk("b.peak",   32'(b_peak),   mb.peak);
      chk("b.trough", 32'(b_trough), mb.trough);
      chk("b.ovf",    32'(b_ovf),    32'(mb.ovf));
      chk("b.meas",   32'(b_meas),   32'(mb.meas));
      chk("b.rev",    32'(b_rev),    32'(mb.rev));
      chk("b.dir",    32'(b_dir),    32'(mb.dir_o));
      chk("b.idle",   32'(b_idle),   32'(mb.idle));
   endtask

   task automatic clr_stats();
      n_meas_a = 0; n_meas_b = 0; last_meas_a = 0; gap_a = 0;
   endtask

   // One clock: drive at the falling edge, check 1 time unit after the rising edge
   task automatic step(input bit v, input logic [7:0] s);
      sample_vld = v;
      sample_in  = s;
      @(posedge Clk);
      ma = m_step(ma, v, int'(s), 65535);
      mb = m_step(mb, v, int'(s), 255);
      cyc_no++;
      #1;
      check_all();
      if (a_meas === 1'b1) begin
         n_meas_a++;
         if (last_meas_a != 0) gap_a = cyc_no - last_meas_a;
         last_meas_a = cyc_no;
      end
      if (b_meas === 1'b1) n_meas_b++;
      @(negedge Clk);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      sample_vld = 1'($urandom_range(0, 1));
      sample_in  = 8'($urandom);
      @(posedge Clk);
      ma = m_clear();
      mb = m_clear();
      cyc_no++;
      #1;
      check_all();
      chk("rst.period", 32'(a_period), 0);
      chk("rst.peak",   32'(a_peak),   0);
      chk("rst.trough", 32'(a_trough), 0);
      chk("rst.meas",   32'(a_meas),   0);
      chk("rst.idle",   32'(a_idle),   0);
      chk("rst.dir",    32'(a_dir),    0);
      @(negedge Clk);
      rst = 1'b0;
   endtask

   initial begin
      int cur, seg_left, seg_kind, stepsz;
      rst = 1'b1;
      sample_vld = 1'b0;
      sample_in = '0;
      for (int k = 0; k < 35; k++)
         tbl[k] = (k <= 17) ? (127 * k) / 17 : (127 * (34 - k)) / 16;
      ma = m_clear();
      mb = m_clear();
      @(negedge Clk);

      // Full table, one sample per clock
      do_reset(); clr_stats();
      for (int i = 0; i < 35 * 6; i++) step(1'b1, 8'(tbl[i % 35]));
      chk("t1.nmeas",  n_meas_a, 4);
      chk("t1.period", 32'(a_period), 35);
      chk("t1.peak",   32'(a_peak), 127);
      chk("t1.trough", 32'(a_trough), 0);
      chk("t1.ovf",    32'(a_ovf), 0);
      chk("t1.gap",    gap_a, 35);

      // Every other table entry
      do_reset(); clr_stats();
      for (int i = 0; i < 18 * 8; i++) step(1'b1, 8'(tbl[(i % 18) * 2]));
      chk("t2.nmeas",  n_meas_a, 6);
      chk("t2.period", 32'(a_period), 18);
      chk("t2.peak",   32'(a_peak), 127);
      chk("t2.trough", 32'(a_trough), 0);

      // Full table with a stall after every sample; stalled data is junk
      do_reset(); clr_stats();
      for (int i = 0; i < 35 * 6; i++) begin
         step(1'b1, 8'(tbl[i % 35]));
         step(1'b0, 8'($urandom));
      end
      chk("t3.nmeas",  n_meas_a, 4);
      chk("t3.period", 32'(a_period), 35);
      chk("t3.gap",    gap_a, 70);

      // Flat hold mid-rise, then resume
      do_reset(); clr_stats();
      for (int i = 0; i < 80; i++) step(1'b1, 8'(tbl[i % 35]));
      chk("t4.premeas", n_meas_a, 1);
      for (int j = 0; j < LIMIT; j++) begin
         step(1'b1, 8'd0);
         if (j == LIMIT - 2) chk("t4.idle63", 32'(a_idle), 0);
         if (j == LIMIT - 1) chk("t4.idle64", 32'(a_idle), 1);
      end
      clr_stats();
      for (int i = 0; i < 70; i++) step(1'b1, 8'(tbl[i % 35]));
      chk("t4.nomeas", n_meas_a, 0);
      chk("t4.resumed", 32'(a_idle), 0);
      for (int i = 70; i < 105; i++) step(1'b1, 8'(tbl[i % 35]));
      chk("t4.meas", n_meas_a, 1);
      chk("t4.period", 32'(a_period), 35);

      // Long triangle: saturates the 8-bit counter only
      do_reset(); clr_stats();
      for (int i = 0; i < 910; i++) step(1'b1, 8'(((i % 300) <= 150) ? (i % 300) : 300 - (i % 300)));
      chk("t5.nmeas",   n_meas_b, 2);
      chk("t5.bperiod", 32'(b_period), 255);
      chk("t5.bovf",    32'(b_ovf), 1);
      chk("t5.bpeak",   32'(b_peak), 150);
      chk("t5.aperiod", 32'(a_period), 300);
      chk("t5.aovf",    32'(a_ovf), 0);

      // Reset mid-rise discards the reference trough
      do_reset(); clr_stats();
      for (int i = 0; i < 80; i++) step(1'b1, 8'(tbl[i % 35]));
      do_reset(); clr_stats();
      for (int i = 0; i < 70; i++) step(1'b1, 8'(tbl[i % 35]));
      chk("t6.nomeas", n_meas_a, 0);
      for (int i = 70; i < 105; i++) step(1'b1, 8'(tbl[i % 35]));
      chk("t6.meas", n_meas_a, 1);

      // Random segments: ramps, plateaus (some long enough to go idle), jitter, stalls
      do_reset(); clr_stats();
      cur = 128; seg_left = 0; seg_kind = 0; stepsz = 1;
      for (int i = 0; i < 2500; i++) begin
         if (seg_left == 0) begin
            seg_kind = int'($urandom_range(0, 3));
            seg_left = (seg_kind == 2) ? int'($urandom_range(1, 80)) : int'($urandom_range(3, 40));
            stepsz   = int'($urandom_range(1, 6));
         end
         if ($urandom_range(0, 3) == 0) begin
            step(1'b0, 8'($urandom));
         end else begin
            case (seg_kind)
               0: cur += stepsz;
               1: cur -= stepsz;
               2: cur = cur;
               default: cur += int'($urandom_range(0, 4)) - 2;
            endcase
            if (cur < 0) cur = 0;
            if (cur > 255) cur = 255;
            step(1'b1, 8'(cur));
            seg_left--;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
